// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the source-side byte streams and the uartTX write port shared
// by the arbiter. The slave modport is the arbiter; master is whoever drives
// the sources and models the uartTX ready flag.
//
// Handshake: a byte moves from source k when valid_i[k] & ready_o[k] are both
// high at a rising clk_i edge. The arbiter raises ready_o[k] only for the
// granted source, and only while tx_rdy_i is high. tx_wr_o is that same
// transfer, mirrored onto uartTX in the same cycle.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
);
    logic [N_REQ-1:0]   req_i;
    logic [N_REQ-1:0]   valid_i;
    logic [8*N_REQ-1:0] data_i;
    logic [N_REQ-1:0]   last_i;
    logic [N_REQ-1:0]   ready_o;
    logic [N_REQ-1:0]   grant_o;
    logic [IDX_W-1:0]   grant_idx_o;
    logic               busy_o;
    logic               tx_wr_o;
    logic [7:0]         tx_data_o;
    logic               tx_rdy_i;

    modport master (
        output req_i, valid_i, data_i, last_i, tx_rdy_i,
        input  ready_o, grant_o, grant_idx_o, busy_o, tx_wr_o, tx_data_o
    );

    modport slave (
        input  req_i, valid_i, data_i, last_i, tx_rdy_i,
        output ready_o, grant_o, grant_idx_o, busy_o, tx_wr_o, tx_data_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uartTX byte-write port between N_REQ
// message sources. A source keeps the grant for a whole message (until
// last_i), optionally capped at MAX_BYTES bytes per grant, so messages
// never interleave on the serial line.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int IDX_W     = 2,
    parameter int MAX_BYTES = 0,
    parameter int CNT_W     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    uart_tx_arbiter_if.slave      bus,
    output logic                  dbg_state_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    int                 cand;
    logic               xfer;
    logic [CNT_W-1:0]   cnt_inc;
    logic               rel_last, rel_max, rel_abandon;

    // Round-robin search: first requester after ptr_q, wrapping modulo N_REQ.
    // The last position visited is ptr_q itself, so the previous owner is
    // only picked again when nobody else is asking.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(ptr_q) + i) % N_REQ;
            if (!pick_found && bus.req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Transfer qualification and release conditions for the granted source.
    always_comb begin
        xfer        = (state_q == GRANT) && bus.valid_i[idx_q] && bus.tx_rdy_i;
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        rel_last    = xfer && bus.last_i[idx_q];
        rel_max     = xfer && (MAX_BYTES != 0) && (cnt_inc == MAX_CNT);
        rel_abandon = !xfer && !bus.req_i[idx_q];
    end

    // Next-state: grant on any request in IDLE, release after a message end,
    // a byte-limit hit or an abandoned request.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                end
                if (rel_last || rel_max || rel_abandon) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = idx_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register; reset restarts arbitration with source 0 first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs: grant status from registers, byte path combinational so the
    // granted source sees uartTX back-pressure with zero latency.
    always_comb begin
        bus.grant_o     = grant_q;
        bus.grant_idx_o = idx_q;
        bus.busy_o      = (state_q == GRANT);
        bus.ready_o     = (state_q == GRANT) ? (grant_q & {N_REQ{bus.tx_rdy_i}}) : '0;
        bus.tx_wr_o     = xfer;
        bus.tx_data_o   = xfer ? bus.data_i[{idx_q, 3'b000} +: 8] : 8'h00;
        dbg_state_o     = (state_q == GRANT);
    end

endmodule
